dma_bus_slave: RTL

DMA_BUS_SLAVE -- requirements
Module: dma_bus_slave

---
 rtl/dma_bus_slave_if.sv | 27 ++
 rtl/dma_bus_slave.sv | 117 +++++++++++
 2 files changed

// File: rtl/dma_bus_slave_if.sv
// Bus-side signal bundle for the DMA burst slave; master drives requests, slave drives responses.
interface dma_bus_slave_if;
  logic        begin_transaction_in;
  logic        end_transaction_in;
  logic        read_n_write_in;
  logic [31:0] address_data_in;
  logic [3:0]  byte_enables_in;
  logic [7:0]  burst_size_in;
  logic        data_valid_in;
  logic        busy_in;
  logic [31:0] address_data_out;
  logic        data_valid_out;
  logic        end_transaction_out;
  logic        bus_error_out;

  modport master (
    output begin_transaction_in, end_transaction_in, read_n_write_in, address_data_in,
           byte_enables_in, burst_size_in, data_valid_in, busy_in,
    input  address_data_out, data_valid_out, end_transaction_out, bus_error_out
  );

  modport slave (
    input  begin_transaction_in, end_transaction_in, read_n_write_in, address_data_in,
           byte_enables_in, burst_size_in, data_valid_in, busy_in,
    output address_data_out, data_valid_out, end_transaction_out, bus_error_out
  );
endinterface

// File: rtl/dma_bus_slave.sv
// Word-addressed burst memory slave: decodes a window at baseAddress, serves
// byte-masked write bursts and stallable read bursts with one-cycle memory latency.
module dma_bus_slave #(
  parameter logic [31:0] baseAddress = 32'h5000_0000,
  parameter int          addressBits = 9
) (
  input  logic           clock,
  input  logic           reset,
  dma_bus_slave_if.slave bus
);
  localparam int DEPTH = 1 << addressBits;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WRITE     = 3'd1;
  localparam logic [2:0] READ_WAIT = 3'd2;
  localparam logic [2:0] READ      = 3'd3;
  localparam logic [2:0] END       = 3'd4;
  localparam logic [2:0] ERROR     = 3'd5;

  logic [2:0]             state;
  logic [addressBits-1:0] index;
  logic [7:0]             beats_left;
  logic [31:0]            rdata;
  logic                   rvalid;
  logic                   end_pulse;
  logic                   err_pulse;
  logic [31:0]            mem [DEPTH];

  logic hit, aligned, write_beat;

  assign hit        = bus.address_data_in[31:addressBits+2] == baseAddress[31:addressBits+2];
  assign aligned    = bus.address_data_in[1:0] == 2'b00;
  assign write_beat = (state == WRITE) && bus.data_valid_in && !reset;

  // Storage has no reset so contents survive a bus reset.
  always_ff @(posedge clock) begin
    if (write_beat)
      for (int b = 0; b < 4; b++)
        if (bus.byte_enables_in[b])
          mem[index][8*b +: 8] <= bus.address_data_in[8*b +: 8];
  end

  // beats_left counts beats still owed after the one in flight; zero marks the last.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      beats_left <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      end_pulse  <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      end_pulse <= 1'b0;
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.begin_transaction_in && hit) begin
            if (!aligned) begin
              state     <= ERROR;
              err_pulse <= 1'b1;
              end_pulse <= 1'b1;
            end else begin
              index      <= bus.address_data_in[addressBits+1:2];
              beats_left <= bus.burst_size_in;
              state      <= bus.read_n_write_in ? READ_WAIT : WRITE;
            end
          end
        end
        WRITE: begin
          if (bus.data_valid_in) begin
            index      <= index + 1'b1;
            beats_left <= beats_left - 8'd1;
            if (beats_left == 8'd0) state <= IDLE;
          end
          if (bus.end_transaction_in) state <= IDLE;
        end
        READ_WAIT: begin
          if (bus.end_transaction_in) begin
            state <= IDLE;
          end else begin
            rdata  <= mem[index];
            rvalid <= 1'b1;
            index  <= index + 1'b1;
            state  <= READ;
          end
        end
        READ: begin
          if (bus.end_transaction_in) begin
            state  <= IDLE;
            rvalid <= 1'b0;
            rdata  <= '0;
          end else if (!bus.busy_in) begin
            if (beats_left == 8'd0) begin
              rvalid    <= 1'b0;
              rdata     <= '0;
              end_pulse <= 1'b1;
              state     <= END;
            end else begin
              rdata      <= mem[index];
              index      <= index + 1'b1;
              beats_left <= beats_left - 8'd1;
            end
          end
        end
        END:     state <= IDLE;
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.address_data_out    = rdata;
  assign bus.data_valid_out      = rvalid;
  assign bus.end_transaction_out = end_pulse;
  assign bus.bus_error_out       = err_pulse;
endmodule
